// File: rtl/load_wb_pkg.sv
// Shared types, widths and decode helpers for the load/ALU writeback stage.
package load_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned TMO_W  = 8;

  // Writeback FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } wb_state_e;

  // Load funct3 codes; anything not listed behaves as LW
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Byte lane index of the final byte for a given load width
  function automatic logic [LANE_W-1:0] last_lane(input logic [F3_W-1:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Execute-side handshake, SPI byte stream and register-file write port.
interface load_writeback_if;
  import load_wb_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic                  wb_is_load;
  logic [REG_AW-1:0]     wb_rd;
  logic [F3_W-1:0]       wb_funct3;
  logic [XLEN-1:0]       wb_alu;
  logic                  mem_byte_valid;
  logic [BYTE_W-1:0]     mem_byte;
  logic                  mem_byte_ready;
  logic                  WE3;
  logic [REG_AW-1:0]     A3;
  logic [XLEN-1:0]       WD3;
  logic                  busy;
  logic                  load_err;

  // Upstream side: execute stage plus the SPI memory controller
  modport master (
    output wb_valid, wb_is_load, wb_rd, wb_funct3, wb_alu,
    output mem_byte_valid, mem_byte,
    input  wb_ready, mem_byte_ready, WE3, A3, WD3, busy, load_err
  );

  // Writeback stage side
  modport slave (
    input  wb_valid, wb_is_load, wb_rd, wb_funct3, wb_alu,
    input  mem_byte_valid, mem_byte,
    output wb_ready, mem_byte_ready, WE3, A3, WD3, busy, load_err
  );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load word according to funct3.
module load_extend
  import load_wb_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [F3_W-1:0] funct3_i,
  output logic [XLEN-1:0] result_c
);

  // Select width and extension; illegal codes fall through as a full word
  always_comb begin
    result_c = word_i;
    case (funct3_i)
      F3_LB:   result_c = {{(XLEN-8){word_i[7]}}, word_i[7:0]};
      F3_LBU:  result_c = {{(XLEN-8){1'b0}}, word_i[7:0]};
      F3_LH:   result_c = {{(XLEN-16){word_i[15]}}, word_i[15:0]};
      F3_LHU:  result_c = {{(XLEN-16){1'b0}}, word_i[15:0]};
      default: result_c = word_i;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage: sole driver of the register-file write port.
// ALU results are written directly; loads are assembled little-endian from
// the SPI byte stream and extended before the write.
// Optional feature macro: LOAD_TIMEOUT_EN (abort a load after TIMEOUT_CYCLES
// idle cycles between bytes and pulse load_err).
module load_writeback
  import load_wb_pkg::*;
#(
  parameter int unsigned MAX_REG        = 18,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           CLK,
  input  logic           reset_n,
  load_writeback_if.slave bus
);

  wb_state_e           state_q, state_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [F3_W-1:0]     f3_q, f3_d;
  logic [LANE_W-1:0]   count_q, count_d;
  logic [XLEN-1:0]     asm_q, asm_d;
  logic [REG_AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0]     wd3_q, wd3_d;
  logic                we3_q, we3_d;
  logic                wb_ready_q;
  logic                mbr_q;
  logic                busy_q;

  logic                wb_fire_c;
  logic                byte_fire_c;
  logic                timeout_c;
  logic [XLEN-1:0]     asm_merge_c;
  logic [XLEN-1:0]     ext_c;

  // Write is suppressed for x0 and for unimplemented registers
  function automatic logic rd_ok(input logic [REG_AW-1:0] rd);
    return (rd != '0) && (32'(rd) <= MAX_REG);
  endfunction

  assign wb_fire_c   = bus.wb_valid && wb_ready_q;
  assign byte_fire_c = bus.mem_byte_valid && mbr_q;

  // Current assembly word with the incoming byte dropped into its lane
  always_comb begin
    asm_merge_c = asm_q;
    asm_merge_c[{count_q, 3'b000} +: BYTE_W] = bus.mem_byte;
  end

  load_extend u_extend (
    .word_i   (asm_merge_c),
    .funct3_i (f3_q),
    .result_c (ext_c)
  );

`ifdef LOAD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q;

  // Idle-cycle counter: cleared outside COLLECT and on every accepted byte
  always_comb begin
    tmo_d = '0;
    if ((state_q == ST_COLLECT) && !byte_fire_c) tmo_d = tmo_q + TMO_W'(1);
  end

  assign timeout_c = (state_q == ST_COLLECT) && !byte_fire_c &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  // Timeout counter and one-cycle abort pulse
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= timeout_c;
    end
  end

  assign bus.load_err = err_q;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo   = TMO_W'(TIMEOUT_CYCLES);
  assign timeout_c    = 1'b0;
  assign bus.load_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    count_d = count_q;
    asm_d   = asm_q;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    we3_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_fire_c) begin
          if (bus.wb_is_load) begin
            rd_d    = bus.wb_rd;
            f3_d    = bus.wb_funct3;
            count_d = '0;
            asm_d   = '0;
            state_d = ST_COLLECT;
          end else begin
            a3_d    = bus.wb_rd;
            wd3_d   = bus.wb_alu;
            we3_d   = rd_ok(bus.wb_rd);
            state_d = ST_WRITE;
          end
        end
      end
      ST_COLLECT: begin
        if (byte_fire_c) begin
          asm_d   = asm_merge_c;
          count_d = count_q + LANE_W'(1);
          if (count_q == last_lane(f3_q)) begin
            a3_d    = rd_q;
            wd3_d   = ext_c;
            we3_d   = rd_ok(rd_q);
            state_d = ST_WRITE;
          end
        end else if (timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      rd_q       <= '0;
      f3_q       <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      a3_q       <= '0;
      wd3_q      <= '0;
      we3_q      <= 1'b0;
      wb_ready_q <= 1'b0;
      mbr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      we3_q      <= we3_d;
      wb_ready_q <= (state_d == ST_IDLE);
      mbr_q      <= (state_d == ST_COLLECT);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus.WE3            = we3_q;
  assign bus.A3             = a3_q;
  assign bus.WD3            = wd3_q;
  assign bus.wb_ready       = wb_ready_q;
  assign bus.mem_byte_ready = mbr_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_load_writeback.sv
// Directed bench for load_writeback with a register-write scoreboard.
module tb_load_writeback;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif
  localparam int unsigned MAXR = 18;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  exp_q[$];

  load_writeback_if bus();

  load_writeback #(.MAX_REG(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_ok(input logic [4:0] rd);
    return (rd != 5'd0) && (int'(rd) <= int'(MAXR));
  endfunction

  // Scoreboard: every register write must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.WE3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, bus.A3}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_A3", {27'd0, bus.A3}, {27'd0, e.a});
        chk("sb_WD3", bus.WD3, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wb(input logic is_load, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu);
    int n = 0;
    while (bus.wb_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (n >= 20) chk("wb_ready_wait", {31'd0, bus.wb_ready}, 32'd1);
    bus.wb_valid   = 1'b1;
    bus.wb_is_load = is_load;
    bus.wb_rd      = rd;
    bus.wb_funct3  = f3;
    bus.wb_alu     = alu;
    step();
    bus.wb_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) step();
    bus.mem_byte_valid = 1'b1;
    bus.mem_byte       = b;
    while (bus.mem_byte_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (n >= 20) chk("byte_ready_wait", {31'd0, bus.mem_byte_ready}, 32'd1);
    step();
    bus.mem_byte_valid = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] alu, input string tag);
    wr_t e;
    e.a = rd;
    e.d = alu;
    if (rd_ok(rd)) exp_q.push_back(e);
    send_wb(1'b0, rd, 3'b000, alu);
    chk({tag, "_we"}, {31'd0, bus.WE3}, {31'd0, rd_ok(rd)});
    chk({tag, "_a3"}, {27'd0, bus.A3}, {27'd0, rd});
    chk({tag, "_wd3"}, bus.WD3, alu);
    chk({tag, "_rdy_low"}, {31'd0, bus.wb_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    step();
    chk({tag, "_we_off"}, {31'd0, bus.WE3}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, bus.wb_ready}, 32'd1);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input int n, input int gap,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [31:0] exp, input string tag);
    logic [7:0] bs [4];
    wr_t e;
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    e.a = rd;
    e.d = exp;
    if (rd_ok(rd)) exp_q.push_back(e);
    send_wb(1'b1, rd, f3, 32'h0);
    for (int i = 0; i < n; i++) send_byte(bs[i], (i == 0) ? 0 : gap);
    chk({tag, "_we"}, {31'd0, bus.WE3}, {31'd0, rd_ok(rd)});
    chk({tag, "_mbr_in_write"}, {31'd0, bus.mem_byte_ready}, 32'd0);
    step();
    chk({tag, "_we_off"}, {31'd0, bus.WE3}, 32'd0);
  endtask

  initial begin
    bus.wb_valid       = 1'b0;
    bus.wb_is_load     = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_funct3      = '0;
    bus.wb_alu         = '0;
    bus.mem_byte_valid = 1'b0;
    bus.mem_byte       = '0;
    reset_n            = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_we3", {31'd0, bus.WE3}, 32'd0);
    chk("rst_a3", {27'd0, bus.A3}, 32'd0);
    chk("rst_wd3", bus.WD3, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.load_err}, 32'd0);
    chk("rst_mbr", {31'd0, bus.mem_byte_ready}, 32'd0);
    chk("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);

    // ALU writeback and suppressed writes
    do_alu(5'd5, 32'hDEAD_BEEF, "alu_r5");
    do_alu(5'd0, 32'h1111_2222, "alu_r0");
    do_alu(5'd19, 32'h3333_4444, "alu_r19");
    do_alu(5'd18, 32'h0BAD_F00D, "alu_r18");

    // Byte and halfword loads
    do_load(5'd6, 3'b000, 1, 0, 8'h80, 8'h00, 8'h00, 8'h00, 32'hFFFF_FF80, "lb");
    do_load(5'd6, 3'b100, 1, 0, 8'h80, 8'h00, 8'h00, 8'h00, 32'h0000_0080, "lbu");
    do_load(5'd7, 3'b001, 2, 0, 8'h34, 8'h85, 8'h00, 8'h00, 32'hFFFF_8534, "lh");
    do_load(5'd7, 3'b101, 2, 0, 8'h34, 8'h85, 8'h00, 8'h00, 32'h0000_8534, "lhu");

    // Word load with two idle cycles between bytes
    do_load(5'd8, 3'b010, 4, 2, 8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678, "lw_gap");

    // Illegal funct3 acts as LW; suppressed load to x0
    do_load(5'd18, 3'b011, 4, 0, 8'h01, 8'h02, 8'h03, 8'h84, 32'h8403_0201, "ill_f3");
    do_load(5'd0, 3'b000, 1, 0, 8'h11, 8'h00, 8'h00, 8'h00, 32'h0000_0011, "lb_r0");

    // A byte offered while idle is held until COLLECT
    bus.mem_byte_valid = 1'b1;
    bus.mem_byte       = 8'h55;
    step();
    chk("idle_mbr0", {31'd0, bus.mem_byte_ready}, 32'd0);
    step();
    chk("idle_mbr1", {31'd0, bus.mem_byte_ready}, 32'd0);
    do_load(5'd10, 3'b100, 1, 0, 8'h55, 8'h00, 8'h00, 8'h00, 32'h0000_0055, "held_byte");

    // Reset in the middle of a word load discards partial lanes
    send_wb(1'b1, 5'd11, 3'b010, 32'h0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_mbr", {31'd0, bus.mem_byte_ready}, 32'd0);
    chk("mid_rst_we3", {31'd0, bus.WE3}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("mid_rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    do_load(5'd7, 3'b000, 1, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 32'h0000_007F, "lb_after_rst");

`ifdef LOAD_TIMEOUT_EN
    // Load with no bytes aborts after the idle limit
    begin
      int err_cnt = 0;
      int we_cnt  = 0;
      send_wb(1'b1, 5'd9, 3'b000, 32'h0);
      for (int i = 0; i < 20; i++) begin
        if (bus.load_err === 1'b1) err_cnt++;
        if (bus.WE3 === 1'b1) we_cnt++;
        step();
      end
      chk("tmo_err_pulses", 32'(err_cnt), 32'd1);
      chk("tmo_no_write", 32'(we_cnt), 32'd0);
      chk("tmo_idle", {31'd0, bus.busy}, 32'd0);
      chk("tmo_ready", {31'd0, bus.wb_ready}, 32'd1);
    end
`else
    // A long gap stalls the load without error
    begin
      wr_t e;
      e.a = 5'd12;
      e.d = 32'h0000_7FFF;
      exp_q.push_back(e);
      send_wb(1'b1, 5'd12, 3'b101, 32'h0);
      repeat (30) step();
      chk("stall_err", {31'd0, bus.load_err}, 32'd0);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
      send_byte(8'hFF, 0);
      send_byte(8'h7F, 0);
      chk("stall_we", {31'd0, bus.WE3}, 32'd1);
      step();
    end
`endif

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
